calc_ctrl: RTL and testbench

- Control unit for the binary calculator.
- Deserialises the 5-bit unlock key and decides whether the calculator is active and which mode it runs in.
- Sequences the ALU result capture, the 4-entry result memory (store/load) and the serial transmitter handshake.
- Drives the CalcBusy/CalcActive/CalcMode status seen at the calculator top level.

---
 rtl/calc_pkg.sv | 15 +
 rtl/calc_if.sv | 30 +++
 rtl/calc_key_check.sv | 82 ++++++++
 rtl/calc_ctrl.sv | 134 +++++++++++++
 tb/tb_calc_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control slice.
// Optional feature macro: CALC_LOCKOUT_EN (key lockout after repeated failures).
package calc_pkg;

  typedef enum logic [2:0] {
    LOCKED, CHECK, IDLE, EXEC, STORE, LOAD, TXS, TXW
  } calcStateT;

  localparam logic [3:0] PASS_CODE       = 4'b0101;
  localparam int         KEY_LEN         = 5;
  localparam int         DEF_ADDR_W      = 2;
  localparam int         DEF_OPK_W       = 20;
  localparam int         DEF_LOCKOUT_CYC = 64;

endpackage

// File: rtl/calc_if.sv
// Command / memory / serialiser handshake bundle between the calculator
// datapath (master side) and calc_ctrl (slave side).
interface calc_if
  import calc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OPK_W  = DEF_OPK_W
);
  logic              ValidCmd;
  logic              RW;
  logic [ADDR_W-1:0] Addr;
  logic [OPK_W-1:0]  OpKey;
  logic              TxDone;
  logic              AluCapture;
  logic              MemWe;
  logic              MemRe;
  logic [ADDR_W-1:0] MemAddr;
  logic              TxStart;
  logic              TxSrcMem;

  modport master (
    output ValidCmd, RW, Addr, OpKey, TxDone,
    input  AluCapture, MemWe, MemRe, MemAddr, TxStart, TxSrcMem
  );

  modport slave (
    input  ValidCmd, RW, Addr, OpKey, TxDone,
    output AluCapture, MemWe, MemRe, MemAddr, TxStart, TxSrcMem
  );
endinterface

// File: rtl/calc_key_check.sv
// Serial unlock-key collector: shift register, bit counter and compare.
// With CALC_LOCKOUT_EN, three consecutive failures block key entry for
// LOCKOUT_CYC cycles.
module calc_key_check
  import calc_pkg::*;
#(
  parameter logic [3:0] PASS_CODE = calc_pkg::PASS_CODE
`ifdef CALC_LOCKOUT_EN
  , parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC
`endif
) (
  input  logic Clk,
  input  logic Reset,
  input  logic keyEn,     // controller is in LOCKED
  input  logic keyChk,    // controller is in CHECK
  input  logic InputKey,
  output logic keyLast,   // last key bit is being sampled this cycle
  output logic keyOk,
  output logic keyMode,
  output logic PassErr
`ifdef CALC_LOCKOUT_EN
  , output logic Locked
`endif
);

  logic [KEY_LEN-1:0] key;
  logic [2:0]         bitCnt;
  logic               sampleEn;

`ifdef CALC_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  logic [LW-1:0] lockCnt;
  logic [1:0]    failCnt;

  assign Locked   = (lockCnt != '0);
  assign sampleEn = keyEn && !Locked;
`else
  assign sampleEn = keyEn;
`endif

  assign keyLast = sampleEn && (bitCnt == 3'(KEY_LEN - 1));
  assign keyOk   = (key[3:0] == PASS_CODE);
  assign keyMode = key[KEY_LEN-1];

  // Collect one bit per cycle LSB first; the counter wraps to 0 after the
  // last bit so a rejected key restarts cleanly.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      key     <= '0;
      bitCnt  <= '0;
      PassErr <= 1'b0;
    end else begin
      PassErr <= keyChk && !keyOk;
      if (sampleEn) begin
        key[bitCnt] <= InputKey;
        bitCnt      <= keyLast ? 3'd0 : bitCnt + 3'd1;
      end
    end
  end

`ifdef CALC_LOCKOUT_EN
  // Failure counter and lockout timer; the counter is cleared as the lockout
  // starts, which is indistinguishable from clearing it when it expires.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      failCnt <= '0;
      lockCnt <= '0;
    end else if (lockCnt != '0) begin
      lockCnt <= lockCnt - LW'(1);
    end else if (keyChk) begin
      if (keyOk)
        failCnt <= '0;
      else if (failCnt == 2'd2) begin
        failCnt <= '0;
        lockCnt <= LW'(LOCKOUT_CYC);
      end else
        failCnt <= failCnt + 2'd1;
    end
  end
`endif

endmodule

// File: rtl/calc_ctrl.sv
// Calculator control unit: unlock, command accept and sequencing of ALU
// capture, result memory and serial transmit.
// Optional feature macro: CALC_LOCKOUT_EN (adds the Locked output).
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int         ADDR_W    = DEF_ADDR_W,
  parameter int         OPK_W     = DEF_OPK_W,
  parameter logic [3:0] PASS_CODE = calc_pkg::PASS_CODE
`ifdef CALC_LOCKOUT_EN
  , parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC
`endif
) (
`ifdef CALC_LOCKOUT_EN
  output logic  Locked,
`endif
  input  logic  Clk,
  input  logic  Reset,
  input  logic  InputKey,
  calc_if.slave bus,
  output logic  PassErr,
  output logic  CalcBusy,
  output logic  CalcActive,
  output logic  CalcMode
);

  calcStateT             state;
  logic                  keyLast, keyOk, keyMode;
  logic                  hasCmd;
  logic [OPK_W+ADDR_W:0] snap, lastSnap;
  logic                  accept;

  calc_key_check #(
    .PASS_CODE(PASS_CODE)
`ifdef CALC_LOCKOUT_EN
    , .LOCKOUT_CYC(LOCKOUT_CYC)
`endif
  ) u_keyCheck (
`ifdef CALC_LOCKOUT_EN
    .Locked  (Locked),
`endif
    .Clk     (Clk),
    .Reset   (Reset),
    .keyEn   (state == LOCKED),
    .keyChk  (state == CHECK),
    .InputKey(InputKey),
    .keyLast (keyLast),
    .keyOk   (keyOk),
    .keyMode (keyMode),
    .PassErr (PassErr)
  );

  // A held ValidCmd only re-fires when the operands, direction or address move.
  assign snap   = {bus.OpKey, bus.RW, bus.Addr};
  assign accept = bus.ValidCmd && (!hasCmd || (snap != lastSnap));

  // Main sequencer; every output is registered and pulses default low.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state          <= LOCKED;
      CalcActive     <= 1'b0;
      CalcMode       <= 1'b0;
      CalcBusy       <= 1'b0;
      hasCmd         <= 1'b0;
      lastSnap       <= '0;
      bus.AluCapture <= 1'b0;
      bus.MemWe      <= 1'b0;
      bus.MemRe      <= 1'b0;
      bus.MemAddr    <= '0;
      bus.TxStart    <= 1'b0;
      bus.TxSrcMem   <= 1'b0;
    end else begin
      bus.AluCapture <= 1'b0;
      bus.MemWe      <= 1'b0;
      bus.MemRe      <= 1'b0;
      bus.TxStart    <= 1'b0;
      unique case (state)
        LOCKED: if (keyLast) state <= CHECK;
        CHECK: begin
          if (keyOk) begin
            CalcActive <= 1'b1;
            CalcMode   <= keyMode;
            state      <= IDLE;
          end else
            state <= LOCKED;
        end
        IDLE: begin
          if (accept) begin
            hasCmd      <= 1'b1;
            lastSnap    <= snap;
            bus.MemAddr <= bus.Addr;
            CalcBusy    <= 1'b1;
            if (CalcMode && !bus.RW) begin
              bus.MemRe <= 1'b1;
              state     <= LOAD;
            end else begin
              bus.AluCapture <= 1'b1;
              state          <= EXEC;
            end
          end
        end
        EXEC: begin
          if (CalcMode) begin
            bus.MemWe <= 1'b1;
            state     <= STORE;
          end else begin
            bus.TxStart  <= 1'b1;
            bus.TxSrcMem <= 1'b0;
            state        <= TXS;
          end
        end
        STORE: begin
          CalcBusy <= 1'b0;
          state    <= IDLE;
        end
        LOAD: begin
          bus.TxStart  <= 1'b1;
          bus.TxSrcMem <= 1'b1;
          state        <= TXS;
        end
        // A TxDone coincident with TxStart belongs to an older frame.
        TXS: state <= TXW;
        TXW: begin
          if (bus.TxDone) begin
            CalcBusy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= LOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: unlock, mode 0 compute/transmit, mode 1
// store/load, reset abort, and (with CALC_LOCKOUT_EN) the key lockout.
module tb_calc_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic InputKey = 1'b0;
  logic PassErr, CalcBusy, CalcActive, CalcMode;
`ifdef CALC_LOCKOUT_EN
  logic Locked;
`endif
  int passed = 0;
  int total  = 0;

  calc_if #(.ADDR_W(2), .OPK_W(20)) cbus ();

  calc_ctrl #(.ADDR_W(2), .OPK_W(20)) dut (
`ifdef CALC_LOCKOUT_EN
    .Locked    (Locked),
`endif
    .Clk       (Clk),
    .Reset     (Reset),
    .InputKey  (InputKey),
    .bus       (cbus),
    .PassErr   (PassErr),
    .CalcBusy  (CalcBusy),
    .CalcActive(CalcActive),
    .CalcMode  (CalcMode)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [10:0] outs();
    return {CalcActive, CalcMode, CalcBusy, PassErr, cbus.AluCapture, cbus.MemWe,
            cbus.MemRe, cbus.TxStart, cbus.TxSrcMem, cbus.MemAddr};
  endfunction

  // Five key bits LSB first; leaves the controller in CHECK.
  task automatic sendKey(input logic [4:0] k);
    for (int i = 0; i < 5; i++) begin
      InputKey = k[i];
      tick(1);
    end
    InputKey = 1'b0;
  endtask

  initial begin
    cbus.ValidCmd = 1'b0; cbus.RW = 1'b0; cbus.Addr = '0;
    cbus.OpKey = '0; cbus.TxDone = 1'b0;
    tick(2);
    check("reset_outs", outs(), 0);
    Reset = 1'b1;

    // Wrong key, then mode-1 key straight after.
    sendKey(5'b00111);
    tick(1);
    check("bad_passerr", PassErr, 1);
    check("bad_active", CalcActive, 0);
    sendKey(5'b10101);
    check("key1_pre", CalcActive, 0);
    tick(1);
    check("key1_active", CalcActive, 1);
    check("key1_mode", CalcMode, 1);
    check("key1_passerr", PassErr, 0);
    InputKey = 1'b1;
    tick(6);
    InputKey = 1'b0;
    check("key_ignored", {CalcActive, CalcMode, PassErr, CalcBusy}, 4'b1100);

    // Mode 1 stores to every address.
    cbus.RW = 1'b1; cbus.OpKey = 20'h12345; cbus.ValidCmd = 1'b1;
    for (int a = 0; a < 4; a++) begin
      cbus.Addr = a[1:0];
      tick(1);
      check("st_alucap", cbus.AluCapture, 1);
      check("st_busy", CalcBusy, 1);
      tick(1);
      check("st_we", cbus.MemWe, 1);
      check("st_addr", cbus.MemAddr, a);
      tick(1);
      check("st_idle", {CalcBusy, cbus.MemWe, cbus.TxStart}, 0);
    end
    tick(1);
    check("st_noretrig", cbus.AluCapture, 0);

    // Mode 1 load and transmit from memory.
    cbus.RW = 1'b0; cbus.Addr = 2'd3;
    tick(1);
    check("ld_re", cbus.MemRe, 1);
    check("ld_addr", cbus.MemAddr, 3);
    check("ld_nocap", cbus.AluCapture, 0);
    tick(1);
    check("ld_txstart", cbus.TxStart, 1);
    check("ld_src", cbus.TxSrcMem, 1);
    cbus.TxDone = 1'b1;           // coincident with TXS: must be ignored
    tick(1);
    cbus.TxDone = 1'b0;
    check("ld_txw_busy", {CalcBusy, cbus.TxStart, cbus.TxSrcMem}, 3'b101);
    cbus.Addr = 2'd1;             // new command while busy
    tick(2);
    cbus.ValidCmd = 1'b0;
    tick(1);
    check("ld_busy_hold", {CalcBusy, cbus.MemRe, cbus.AluCapture}, 3'b100);
    cbus.TxDone = 1'b1;
    tick(1);
    cbus.TxDone = 1'b0;
    check("ld_done", CalcBusy, 0);
    tick(2);
    check("ld_not_queued", {CalcBusy, cbus.MemRe, cbus.AluCapture}, 0);
    cbus.TxDone = 1'b1;           // stray TxDone in IDLE
    tick(1);
    cbus.TxDone = 1'b0;
    check("stray_txdone", {CalcBusy, cbus.TxStart}, 0);

    // Mode 0 compute and transmit.
    Reset = 1'b0;
    tick(1);
    Reset = 1'b1;
    sendKey(5'b00101);
    check("key0_pre", CalcActive, 0);
    tick(1);
    check("key0_active_mode", {CalcActive, CalcMode, PassErr}, 3'b100);
    cbus.OpKey = {4'd5, 8'd5, 8'd1}; cbus.Addr = 2'd2; cbus.RW = 1'b0; cbus.ValidCmd = 1'b1;
    tick(1);
    check("m0_alucap", {cbus.AluCapture, cbus.MemRe, CalcBusy}, 3'b101);
    tick(1);
    check("m0_txstart", {cbus.TxStart, cbus.TxSrcMem, cbus.AluCapture}, 3'b100);
    check("m0_addr", cbus.MemAddr, 2);
    tick(19);
    check("m0_txw_busy", {CalcBusy, cbus.TxStart}, 2'b10);
    cbus.TxDone = 1'b1;
    tick(1);
    cbus.TxDone = 1'b0;
    check("m0_done", CalcBusy, 0);
    tick(1);
    check("m0_noretrig", {cbus.AluCapture, CalcBusy}, 0);
    cbus.OpKey = {4'd5, 8'd5, 8'd2};
    tick(1);
    check("m0_newcmd", cbus.AluCapture, 1);
    tick(2);                      // now in TXW

    // Reset mid-transmit aborts at once.
    Reset = 1'b0;
    tick(1);
    check("rst_abort", outs(), 0);
    tick(1);
    check("rst_hold", outs(), 0);
    Reset = 1'b1; cbus.ValidCmd = 1'b0;
    tick(2);
    check("rst_locked", {CalcActive, CalcBusy}, 0);

`ifdef CALC_LOCKOUT_EN
    Reset = 1'b0;
    tick(1);
    Reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      sendKey(5'b00000);
      tick(1);
    end
    check("lo_locked", Locked, 1);
    check("lo_passerr", PassErr, 1);
    sendKey(5'b00101);
    tick(1);
    check("lo_rejected", CalcActive, 0);
    tick(57);
    check("lo_still", Locked, 1);
    tick(1);
    check("lo_end", Locked, 0);
    sendKey(5'b00101);
    tick(1);
    check("lo_active", CalcActive, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
